// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared FSM state and write-mode constants for sp_ram_param
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

endpackage

// File: rtl/sp_ram_if.sv
// rtl/sp_ram_if.sv - request/return bundle between a requester and sp_ram_param
interface sp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              perr_inject;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, perr_inject,
        input  req_ready, rd_valid, rd_data, rd_perr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, perr_inject,
        output req_ready, rd_valid, rd_data, rd_perr
    );

endinterface

// File: rtl/sp_ram_array.sv
// rtl/sp_ram_array.sv - storage only: one write port, one registered read port
module sp_ram_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read samples the pre-write word, so a same-address write reads old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_ram_param.sv
// rtl/sp_ram_param.sv - single-port RAM with clear sequencer; SP_RAM_PARITY_EN adds a stored parity bit
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 6,
    parameter int                WRITE_MODE = WM_READ_FIRST,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr_req,
    sp_ram_if.slave  bus,
    output logic     busy
);

`ifdef SP_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              rd_valid_q;
    logic              wf_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              clearing;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  arr_rdata;
    logic [MEM_W-1:0]  req_word;
    logic [MEM_W-1:0]  clr_word;

    assign clearing      = (state_q == ST_CLEAR);
    assign bus.req_ready = (state_q == ST_READY);
    assign busy          = clearing;
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d    = ST_READY;
                    clr_addr_d = '0;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

`ifdef SP_RAM_PARITY_EN
    assign req_word = {(^bus.req_wdata) ^ bus.perr_inject, bus.req_wdata};
    assign clr_word = {^CLEAR_VAL, CLEAR_VAL};
`else
    logic unused_perr_inject;
    assign unused_perr_inject = bus.perr_inject;
    assign req_word = bus.req_wdata;
    assign clr_word = CLEAR_VAL;
`endif

    assign arr_we    = ~rst & (clearing | (accept & bus.req_we));
    assign arr_addr  = clearing ? clr_addr_q : bus.req_addr;
    assign arr_wdata = clearing ? clr_word : req_word;

    sp_ram_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .rd_en (accept),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Write-first returns bypass the array; wf_q/wdata_q only move on accept so rd_data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            wf_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            rd_valid_q <= accept;
            if (accept) begin
                wf_q    <= bus.req_we & (WRITE_MODE == WM_WRITE_FIRST);
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = wf_q ? wdata_q : arr_rdata[DATA_W-1:0];

`ifdef SP_RAM_PARITY_EN
    assign bus.rd_perr = rd_valid_q & ~wf_q & (arr_rdata[DATA_W] != (^arr_rdata[DATA_W-1:0]));
`else
    assign bus.rd_perr = 1'b0;
`endif

endmodule
